des3_cbc_sequencer: RTL and testbench
=====================================

Name: des3_cbc_sequencer

Overview:
- Streams multi-block messages through the single-block des3 core.
- Applies ECB or CBC chaining, including the IV XOR and chaining-register update.
- Generates the core start pulse, waits for out_valid, and presents results on a valid/ready output.
- Sits between a DMA/stream front-end and the des3 core; keys are driven to the core separately.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before abort; 8-bit counter is sufficient for the default, width = $clog2(TIMEOUT_CYCLES+1).
- GUARD_CYCLES, 1: cycles after core_start during which core_valid is ignored (stale-valid blanking).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- cfg_cbc  in  1  1=CBC, 0=ECB; sampled at block accept
- cfg_decrypt  in  1  1=decrypt; sampled at block accept
- iv_load  in  1  pulse: load iv_i into chain register
- iv_i  in  64  initialization vector
- err_clr  in  1  pulse: clear sticky errors
- in_valid  in  1  input block valid
- in_ready  out  1  input block accepted when in_valid&&in_ready
- in_data  in  64  input block (PT or CT)
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  64  result block
- core_start  out  1  one-cycle start pulse to des3
- core_decrypt  out  1  decrypt select to des3, held from LOAD through WAIT
- core_din  out  64  des3 input block
- core_dout  in  64  des3 output block
- core_valid  in  1  des3 out_valid
- busy  out  1  state != IDLE
- blk_count  out  32  completed blocks, wraps 0xFFFFFFFF->0
- err_timeout  out  1  sticky: WAIT timed out
- err_iv_busy  out  1  sticky: iv_load while busy (load ignored)

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0; chain=0, blk_count=0, errors=0.
  - Reset mid-operation aborts immediately; no out_valid follows.
- States and transitions:
  - IDLE: in_ready=1.
    - On accept, latch in_data, cfg_cbc and cfg_decrypt; go to LOAD.
    - iv_load in IDLE loads chain<=iv_i. If iv_load and accept occur in the same cycle, the new IV is used for that block.
  - LOAD (1 cycle): core_start=1; core_din is driven as listed under Datapath; go to GUARD.
  - GUARD: GUARD_CYCLES cycles, core_valid ignored; then go to WAIT.
  - WAIT: the timeout counter increments.
    - On core_valid=1: capture the result into out_data and update chain; go to OUT.
    - If the counter reaches TIMEOUT_CYCLES with no core_valid: set err_timeout, leave chain unchanged, drop the block, go to IDLE.
  - OUT: out_valid=1 and out_data held stable until out_ready.
    - On handshake: blk_count++, go to IDLE.
    - out_ready already high on entry completes in that same cycle.
- Datapath:
  - core_din:
    - CBC encrypt: core_din = in ^ chain.
    - Otherwise: core_din = in.
  - CBC encrypt: result = core_dout; chain <= core_dout.
  - CBC decrypt: result = core_dout ^ chain; chain <= latched input block.
  - ECB: result = core_dout; chain unchanged.
  - core_din and core_decrypt are registered and held from LOAD until leaving WAIT.
- Accept timing: in_ready is 0 outside IDLE; back-to-back throughput is one block per (core latency + GUARD_CYCLES + 3) cycles minimum.
- Error flags:
  - iv_load while busy: ignored, sets err_iv_busy.
  - err_clr clears both sticky flags. An error event in the same cycle as err_clr wins (flag stays set).
- cfg changes outside block accept have no effect on an in-flight block.

Decomposition:
- Package des3_seq_pkg:
  - state enum IDLE/LOAD/GUARD/WAIT/OUT.
  - Mode constants.
  - 64-bit block typedef.
  - Timeout counter width function.
- One natural sub-module, des3_seq_chain: the chain register plus pre/post XOR mux, with load_iv, update and mode inputs. FSM and counters stay in the top.

Test Plan:
- Bench uses a stub core (dout = din ^ 64'hFFFF_FFFF_FFFF_FFFF, core_valid after 20 cycles) except in the last scenario.
- ECB encrypt, stub:
  - Stimulus: in 0x0123456789ABCDEF.
  - Required response: out 0xFEDCBA9876543210; chain stays 0; blk_count=1; core_start high exactly 1 cycle.
- CBC encrypt, stub:
  - Stimulus: IV 0x1111111111111111, blocks 0x0 then 0x0.
  - Required response: outs 0xEEEEEEEEEEEEEEEE then 0xEEEEEEEEEEEEEEEE ^ 0xFFFF_FFFF_FFFF_FFFF... i.e. second core_din=0xEEEEEEEEEEEEEEEE, out 0x1111111111111111.
- CBC decrypt inverse:
  - Stimulus: feed those two outputs with the same IV.
  - Required response: 0x0, 0x0 recovered.
- Backpressure and iv_load while busy:
  - Stimulus: hold out_ready=0 for 50 cycles; pulse iv_load mid-block.
  - Required response: out_data stable, in_ready=0 throughout; err_iv_busy=1; chain unaffected; err_clr clears the flag.
- Timeout, then mid-WAIT reset:
  - Stimulus: stub never asserts core_valid.
  - Required response: after 255 WAIT cycles err_timeout=1, IDLE, no out_valid.
  - Stimulus: wb_rst_i asserted mid-WAIT.
  - Required response: all outputs 0 next cycle.
- Real des3 core, keys all 0x133457799BBCDFF1 (EDE degenerates to DES), ECB:
  - Stimulus: 0x0123456789ABCDEF.
  - Required response: 0x85E813540F0AB405; decrypt round-trips.

Source files
------------

// File: rtl/des3_seq_pkg.sv
// Shared types and helpers for the 3DES block-chaining sequencer.
//   state_t   : sequencer FSM states
//   block_t   : one 64-bit cipher block
//   mode_t    : chaining mode + direction, latched per block
//   cnt_width : width needed for a counter that must reach max_count
package des3_seq_pkg;

    typedef logic [63:0] block_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GUARD = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;
    localparam logic DIR_ENC  = 1'b0;
    localparam logic DIR_DEC  = 1'b1;

    typedef struct packed {
        logic cbc;
        logic decrypt;
    } mode_t;

    localparam block_t BLOCK_ZERO = '0;

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/des3_seq_chain.sv
// Chaining register with the pre-core and post-core XOR muxes.
//   clk, rst      : clock, synchronous active-high reset
//   load_iv, iv   : load the chain register with a new IV
//   update        : commit the chaining value after a CBC block completes
//   pre_mode      : mode presented at block accept (selects the pre-XOR)
//   blk_in        : block presented at accept
//   din_mix       : value to register into the core input
//   mode          : mode latched for the in-flight block
//   blk_held      : latched input block (next chain value for CBC decrypt)
//   core_dout     : core result
//   result        : core result after the post-XOR
module des3_seq_chain
    import des3_seq_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_iv,
    input  block_t iv,
    input  logic   update,
    input  mode_t  pre_mode,
    input  block_t blk_in,
    output block_t din_mix,
    input  mode_t  mode,
    input  block_t blk_held,
    input  block_t core_dout,
    output block_t result
);

    block_t chain_q;
    block_t chain_eff;

    // An IV loaded in the accept cycle must already apply to that block,
    // so the pre-XOR sees the incoming IV rather than the stale register.
    assign chain_eff = load_iv ? iv : chain_q;

    assign din_mix = (pre_mode.cbc == MODE_CBC && pre_mode.decrypt == DIR_ENC)
                     ? (blk_in ^ chain_eff) : blk_in;

    assign result = (mode.cbc == MODE_CBC && mode.decrypt == DIR_DEC)
                    ? (core_dout ^ chain_q) : core_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= BLOCK_ZERO;
        end else if (load_iv) begin
            chain_q <= iv;
        end else if (update) begin
            chain_q <= (mode.decrypt == DIR_DEC) ? blk_held : core_dout;
        end
    end

endmodule

// File: rtl/des3_cbc_sequencer.sv
// Streams blocks through a single-block 3DES core with ECB/CBC chaining.
//   wb_clk_i, wb_rst_i         : clock, synchronous active-high reset
//   cfg_cbc, cfg_decrypt       : mode, sampled when a block is accepted
//   iv_load, iv_i              : IV load pulse (honoured only while idle)
//   err_clr                    : clears the sticky error flags
//   in_valid/in_ready/in_data  : input block stream
//   out_valid/out_ready/out_data : result block stream
//   core_*                     : handshake and data to/from the 3DES core
//   busy, blk_count            : status; blk_count wraps
//   err_timeout, err_iv_busy   : sticky error flags
//
// state | meaning
// IDLE  | ready for a block, IV may be loaded
// LOAD  | core_start pulse, core input presented
// GUARD | blank core_valid for GUARD_CYCLES after start
// WAIT  | wait for core_valid, bounded by TIMEOUT_CYCLES
// OUT   | result held on the output until out_ready
module des3_cbc_sequencer
    import des3_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GUARD_CYCLES   = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cfg_cbc,
    input  logic        cfg_decrypt,
    input  logic        iv_load,
    input  logic [63:0] iv_i,
    input  logic        err_clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        core_start,
    output logic        core_decrypt,
    output logic [63:0] core_din,
    input  logic [63:0] core_dout,
    input  logic        core_valid,
    output logic        busy,
    output logic [31:0] blk_count,
    output logic        err_timeout,
    output logic        err_iv_busy
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam bit HAS_GUARD = (GUARD_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    block_t           blk_q;
    mode_t            mode_q;
    mode_t            pre_mode;
    block_t           din_mix;
    block_t           result;
    logic             accept;
    logic             load_iv;
    logic             chain_update;
    logic             timeout_evt;
    logic             iv_busy_evt;

    assign pre_mode     = '{cbc: cfg_cbc, decrypt: cfg_decrypt};
    // in_ready is only ever high in IDLE, so accept implies IDLE.
    assign accept       = in_valid && in_ready;
    assign load_iv      = iv_load && (state == IDLE);
    assign iv_busy_evt  = iv_load && (state != IDLE);
    assign chain_update = (state == WAIT) && core_valid && (mode_q.cbc == MODE_CBC);
    assign timeout_evt  = (state == WAIT) && !core_valid && (cnt == TO_LAST);

    des3_seq_chain u_chain (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .load_iv   (load_iv),
        .iv        (iv_i),
        .update    (chain_update),
        .pre_mode  (pre_mode),
        .blk_in    (in_data),
        .din_mix   (din_mix),
        .mode      (mode_q),
        .blk_held  (blk_q),
        .core_dout (core_dout),
        .result    (result)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            blk_q        <= BLOCK_ZERO;
            mode_q       <= '0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= BLOCK_ZERO;
            core_start   <= 1'b0;
            core_decrypt <= 1'b0;
            core_din     <= BLOCK_ZERO;
            busy         <= 1'b0;
            blk_count    <= '0;
            err_timeout  <= 1'b0;
            err_iv_busy  <= 1'b0;
        end else begin
            core_start <= 1'b0;
            // A new error event in the same cycle as err_clr keeps the flag set.
            err_timeout <= timeout_evt | (err_timeout & ~err_clr);
            err_iv_busy <= iv_busy_evt | (err_iv_busy & ~err_clr);

            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        blk_q        <= in_data;
                        mode_q       <= pre_mode;
                        core_din     <= din_mix;
                        core_decrypt <= cfg_decrypt;
                        core_start   <= 1'b1;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= HAS_GUARD ? GUARD : WAIT;
                end
                GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (core_valid) begin
                        out_data     <= result;
                        out_valid    <= 1'b1;
                        core_din     <= BLOCK_ZERO;
                        core_decrypt <= 1'b0;
                        state        <= OUT;
                    end else if (cnt == TO_LAST) begin
                        // Block is dropped; chain register is left untouched.
                        core_din     <= BLOCK_ZERO;
                        core_decrypt <= 1'b0;
                        busy         <= 1'b0;
                        in_ready     <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        blk_count <= blk_count + 32'd1;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des3_cbc_sequencer.sv
// Directed bench for des3_cbc_sequencer with a behavioural core stand-in.
// Core modes: 0 = inverting stub, 1 = never responds, 2 = DES known-answer
// responder for key 133457799BBCDFF1 (triple-key EDE collapses to single DES).
module tb_des3_cbc_sequencer;

    localparam logic [63:0] KAT_PT = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT = 64'h85E813540F0AB405;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cfg_cbc = 1'b0, cfg_decrypt = 1'b0;
    logic        iv_load = 1'b0;
    logic [63:0] iv_i = '0;
    logic        err_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        core_start, core_decrypt;
    logic [63:0] core_din;
    logic [63:0] core_dout = '0;
    logic        core_valid = 1'b0;
    logic        busy;
    logic [31:0] blk_count;
    logic        err_timeout, err_iv_busy;

    des3_cbc_sequencer dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cfg_cbc(cfg_cbc), .cfg_decrypt(cfg_decrypt),
        .iv_load(iv_load), .iv_i(iv_i), .err_clr(err_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_start(core_start), .core_decrypt(core_decrypt), .core_din(core_din),
        .core_dout(core_dout), .core_valid(core_valid),
        .busy(busy), .blk_count(blk_count),
        .err_timeout(err_timeout), .err_iv_busy(err_iv_busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- core stand-in ----------------
    int          stub_mode = 0;
    int          stub_cnt  = 0;
    logic [63:0] stub_din  = '0;
    logic        stub_dec  = 1'b0;

    function automatic logic [63:0] stub_resp(input int m, input logic [63:0] d, input logic dec);
        if (m == 2) begin
            if (!dec && d == KAT_PT) return KAT_CT;
            if (dec && d == KAT_CT)  return KAT_PT;
        end
        return d ^ ONES;
    endfunction

    always @(posedge wb_clk_i) begin
        core_valid <= 1'b0;
        if (wb_rst_i) begin
            stub_cnt <= 0;
        end else if (core_start) begin
            stub_din <= core_din;
            stub_dec <= core_decrypt;
            stub_cnt <= 20;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && stub_mode != 1) begin
                core_valid <= 1'b1;
                core_dout  <= stub_resp(stub_mode, stub_din, stub_dec);
            end
        end
    end

    // ---------------- output scoreboard and monitors ----------------
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    int          ov_cycles = 0;
    int          start_run = 0;
    int          last_run  = 0;

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (out_valid) ov_cycles++;
            if (core_start) start_run++;
            else if (start_run != 0) begin
                last_run  = start_run;
                start_run = 0;
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL out_unexpected: observed=%h expected=none", out_data);
                end
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    checks++;
                    assert (out_data === exp_v) else begin
                        errors++;
                        $error("FAIL out_data: observed=%h expected=%h", out_data, exp_v);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [63:0] d, input logic cbc, input logic dec,
                        input logic with_iv, input logic [63:0] iv);
        int n;
        n = 0;
        @(negedge wb_clk_i);
        while (in_ready !== 1'b1 && n < 500) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_data     = d;
        cfg_cbc     = cbc;
        cfg_decrypt = dec;
        iv_load     = with_iv;
        iv_i        = iv;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        in_valid    = 1'b0;
        iv_load     = 1'b0;
        // mode changes after accept must not touch the in-flight block
        cfg_cbc     = ~cbc;
        cfg_decrypt = ~dec;
        in_data     = ~d;
    endtask

    task automatic wait_count(input string tag, input logic [31:0] target);
        int n;
        n = 0;
        while (blk_count !== target && n < 1000) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk(tag, 64'(blk_count), 64'(target));
    endtask

    task automatic pulse_iv(input logic [63:0] iv);
        @(negedge wb_clk_i);
        iv_load = 1'b1;
        iv_i    = iv;
        @(negedge wb_clk_i);
        iv_load = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int   ov_base;
        int   n;
        logic stable;

        // reset state
        repeat (3) @(negedge wb_clk_i);
        chk("rst_flags", 64'({in_ready, out_valid, core_start, core_decrypt, busy, err_timeout, err_iv_busy}), 64'd0);
        chk("rst_blk_count", 64'(blk_count), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_core_din", core_din, 64'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // ECB encrypt
        exp_q.push_back(64'hFEDCBA9876543210);
        send(64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b0, '0);
        chk("ecb_busy", 64'({busy, in_ready}), 64'b10);
        wait_count("ecb_count", 32'd1);
        chk("ecb_chain", dut.u_chain.chain_q, 64'd0);
        chk("ecb_start_len", 64'(last_run), 64'd1);

        // CBC encrypt, IV loaded while idle
        pulse_iv(64'h1111111111111111);
        exp_q.push_back(64'hEEEEEEEEEEEEEEEE);
        send(64'h0, 1'b1, 1'b0, 1'b0, '0);
        wait_count("cbc_enc_count1", 32'd2);
        chk("cbc_enc_din1", stub_din, 64'h1111111111111111);
        exp_q.push_back(64'h1111111111111111);
        send(64'h0, 1'b1, 1'b0, 1'b0, '0);
        wait_count("cbc_enc_count2", 32'd3);
        chk("cbc_enc_din2", stub_din, 64'hEEEEEEEEEEEEEEEE);
        chk("cbc_enc_chain", dut.u_chain.chain_q, 64'h1111111111111111);

        // CBC decrypt, IV loaded in the same cycle as the first accept
        exp_q.push_back(64'h0);
        send(64'hEEEEEEEEEEEEEEEE, 1'b1, 1'b1, 1'b1, 64'h1111111111111111);
        wait_count("cbc_dec_count1", 32'd4);
        chk("cbc_dec_core_dec", 64'(stub_dec), 64'd1);
        exp_q.push_back(64'h0);
        send(64'h1111111111111111, 1'b1, 1'b1, 1'b0, '0);
        wait_count("cbc_dec_count2", 32'd5);
        chk("cbc_dec_chain", dut.u_chain.chain_q, 64'h1111111111111111);

        // backpressure with an iv_load while busy
        out_ready = 1'b0;
        exp_q.push_back(64'h5A5A5A5A5A5A5A5A);
        send(64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0, 1'b0, '0);
        repeat (4) @(negedge wb_clk_i);
        pulse_iv(64'hDEADBEEFCAFEF00D);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        stable = 1'b1;
        repeat (50) begin
            @(negedge wb_clk_i);
            if (out_data !== 64'h5A5A5A5A5A5A5A5A || in_ready !== 1'b0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        chk("bp_count_held", 64'(blk_count), 64'd5);
        chk("iv_busy_flag", 64'(err_iv_busy), 64'd1);
        chk("iv_busy_chain", dut.u_chain.chain_q, 64'h1111111111111111);
        out_ready = 1'b1;
        wait_count("bp_count", 32'd6);
        @(negedge wb_clk_i);
        err_clr = 1'b1;
        @(negedge wb_clk_i);
        err_clr = 1'b0;
        chk("err_clr", 64'(err_iv_busy), 64'd0);

        // timeout: core never answers
        stub_mode = 1;
        ov_base   = ov_cycles;
        send(64'h7777777777777777, 1'b0, 1'b0, 1'b0, '0);
        repeat (256) @(negedge wb_clk_i);
        chk("timeout_early", 64'(err_timeout), 64'd0);
        @(negedge wb_clk_i);
        chk("timeout_flag", 64'(err_timeout), 64'd1);
        chk("timeout_idle", 64'({busy, in_ready}), 64'b01);
        chk("timeout_no_out", 64'(ov_cycles - ov_base), 64'd0);
        chk("timeout_count", 64'(blk_count), 64'd6);
        chk("timeout_chain", dut.u_chain.chain_q, 64'h1111111111111111);

        // reset in the middle of WAIT
        send(64'h3333333333333333, 1'b0, 1'b1, 1'b0, '0);
        repeat (30) @(negedge wb_clk_i);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("midrst_flags", 64'({in_ready, out_valid, core_start, core_decrypt, busy, err_timeout, err_iv_busy}), 64'd0);
        chk("midrst_core_din", core_din, 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_blk_count", 64'(blk_count), 64'd0);
        wb_rst_i  = 1'b0;
        stub_mode = 0;
        ov_base   = ov_cycles;
        repeat (40) @(negedge wb_clk_i);
        chk("midrst_no_out", 64'(ov_cycles - ov_base), 64'd0);

        // DES known answer, ECB both directions
        stub_mode = 2;
        exp_q.push_back(KAT_CT);
        send(KAT_PT, 1'b0, 1'b0, 1'b0, '0);
        wait_count("kat_enc_count", 32'd1);
        chk("kat_enc_dir", 64'(stub_dec), 64'd0);
        exp_q.push_back(KAT_PT);
        send(KAT_CT, 1'b0, 1'b1, 1'b0, '0);
        wait_count("kat_dec_count", 32'd2);
        chk("kat_dec_dir", 64'(stub_dec), 64'd1);

        @(negedge wb_clk_i);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
